multi_eth_reset_gen: RTL and testbench
======================================

MULTI_ETH_RESET_GEN -- requirements
Module: multi_eth_reset_gen

Interface
REQ-001 SHALL have parameter TIMER_MAX_WIDTH, default 14: width of each channel's delay field and delay counter.
REQ-002 SHALL have parameter RESET_MAX_WIDTH, default 14: width of each channel's pulse-width field and width counter.
REQ-003 SHALL have parameter RESETLOGIC, default 0: active level of every OneShotReset bit; the idle level is ~RESETLOGIC.
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, range 1..16: number of independent reset channels.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port ResetAfter, input, NUM_CHANNELS*TIMER_MAX_WIDTH: per-channel delay in cycles; channel i uses slice [i*TIMER_MAX_WIDTH +: TIMER_MAX_WIDTH].
REQ-008 SHALL have port ResetWidth, input, NUM_CHANNELS*RESET_MAX_WIDTH: per-channel pulse width in cycles, sliced the same way.
REQ-009 SHALL have port ResetTrigger, input, NUM_CHANNELS: per-channel trigger; only a rising edge is acted on.
REQ-010 SHALL have port Mode, input, NUM_CHANNELS: 0 = one-shot (the channel locks after one pulse); 1 = retriggerable.
REQ-011 SHALL have port Rearm, input, NUM_CHANNELS: level-sensitive; returns a locked channel to IDLE.
REQ-012 SHALL have port Cancel, input, NUM_CHANNELS: level-sensitive abort of any pending or active sequence.
REQ-013 SHALL have port OneShotReset, output, NUM_CHANNELS: per-channel registered reset pulse.
REQ-014 SHALL have port Busy, output, NUM_CHANNELS: high while the channel is in WAIT or PULSE.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, WAIT, PULSE and LOCKED.
REQ-016 A trigger rising edge SHALL be detected when ResetTrigger[i] is 1 in the current cycle and its registered previous value is 0.
REQ-017 On an edge in IDLE, the channel SHALL latch its ResetAfter and ResetWidth slices; later changes to these inputs SHALL NOT affect the sequence in progress.
REQ-018 On that edge, the channel SHALL go to WAIT if the latched delay A > 0, to PULSE if A = 0 and the latched width W > 0, and otherwise SHALL take the end-of-pulse transition at once.
REQ-019 WAIT SHALL last exactly A cycles; an edge at cycle t SHALL give the first asserted OneShotReset cycle at t+1+A.
REQ-020 PULSE SHALL assert OneShotReset[i] = RESETLOGIC for exactly W cycles; in every other state the output SHALL be ~RESETLOGIC.
REQ-021 The end-of-pulse transition SHALL go to IDLE if Mode[i] = 1 and to LOCKED if Mode[i] = 0; Mode SHALL be sampled at that transition.
REQ-022 In LOCKED, triggers SHALL be ignored; Rearm[i] = 1 SHALL move the channel to IDLE on the next cycle.
REQ-023 Trigger edges arriving during WAIT or PULSE SHALL be ignored, with no queuing and no restart.
REQ-024 Cancel[i] = 1 SHALL force the channel to IDLE on the next edge from any state and SHALL deassert the output that edge; Cancel has priority over trigger and Rearm.
REQ-025 Counters SHALL be TIMER_MAX_WIDTH and RESET_MAX_WIDTH bits, shall count down, and shall never wrap; the maximum field value gives 2^N-1 cycles.
REQ-026 Channels SHALL share no state; simultaneous edges on all channels SHALL produce fully independent timing.

Reset
REQ-027 While aresetn = 0, every FSM SHALL be in IDLE, counters and edge registers SHALL be 0, OneShotReset SHALL be {NUM_CHANNELS{~RESETLOGIC}}, and Busy SHALL be 0.
REQ-028 A reset asserted mid-sequence SHALL abort that sequence immediately (asynchronously); a trigger held high through reset release SHALL NOT be seen as an edge.

Configuration
REQ-029 With macro MULTI_ETH_RESET_PULSE_COUNT_EN defined, the block SHALL add output PulseCount (NUM_CHANNELS*8): per-channel saturating count of completed pulses, cleared by aresetn and by the channel's Rearm.
REQ-030 Without MULTI_ETH_RESET_PULSE_COUNT_EN, the PulseCount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Ch0: Mode=1, A=3, W=5, edge at cycle 10 -> OneShotReset[0] active during cycles 14..18; Busy[0] high 11..18; then IDLE.
REQ-032 Ch1: Mode=0, A=0, W=2; two edges 20 cycles apart -> one pulse only; after Rearm the next edge gives a second pulse.
REQ-033 Ch2: A=10, W=4; Cancel in cycle 5 of WAIT -> no pulse, Busy low the next cycle, a new edge accepted afterwards.
REQ-034 All 4 channels triggered in the same cycle with A=1,2,3,4 and W=1 -> single-cycle pulses in consecutive cycles, one per channel.
REQ-035 aresetn pulsed low in the middle of PULSE with RESETLOGIC=1 -> output drops to 0 immediately; no pulse after release while the trigger is held high.
REQ-036 With the macro defined: 300 pulses on ch0 in Mode=1 -> PulseCount[7:0] = 255 (saturated); Rearm clears it to 0.

Source files
------------

// File: rtl/multi_eth_reset_gen.sv
// Multi-channel delayed reset-pulse generator: per-channel delay, width, one-shot/retrigger modes.
// Optional per-channel saturating pulse counter on PulseCount, enabled by MULTI_ETH_RESET_PULSE_COUNT_EN.
module multi_eth_reset_gen #(
    parameter int TIMER_MAX_WIDTH = 14,
    parameter int RESET_MAX_WIDTH = 14,
    parameter bit RESETLOGIC      = 1'b0,
    parameter int NUM_CHANNELS    = 4
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    input  logic [NUM_CHANNELS*TIMER_MAX_WIDTH-1:0]   ResetAfter,
    input  logic [NUM_CHANNELS*RESET_MAX_WIDTH-1:0]   ResetWidth,
    input  logic [NUM_CHANNELS-1:0]                   ResetTrigger,
    input  logic [NUM_CHANNELS-1:0]                   Mode,
    input  logic [NUM_CHANNELS-1:0]                   Rearm,
    input  logic [NUM_CHANNELS-1:0]                   Cancel,
    output logic [NUM_CHANNELS-1:0]                   OneShotReset,
    output logic [NUM_CHANNELS-1:0]                   Busy
`ifdef MULTI_ETH_RESET_PULSE_COUNT_EN
    ,
    output logic [NUM_CHANNELS*8-1:0]                 PulseCount
`endif
);

    // state  | meaning
    // IDLE   | waiting for a trigger rising edge
    // WAIT   | delay counter running down, output idle
    // PULSE  | output at RESETLOGIC, width counter running down
    // LOCKED | one-shot done; triggers ignored until Rearm
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_PULSE  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam int TW = TIMER_MAX_WIDTH;
    localparam int RW = RESET_MAX_WIDTH;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        state_t         state, state_nx;
        logic [TW-1:0]  dcnt, dcnt_nx;
        logic [RW-1:0]  wcnt, wcnt_nx;
        logic           trig_prev;
        logic           armed;
        logic           out_q;
        logic           trig_edge;
        logic           pulse_done;
        logic [TW-1:0]  after_in;
        logic [RW-1:0]  width_in;
        state_t         end_state;

        assign after_in  = ResetAfter[i*TW +: TW];
        assign width_in  = ResetWidth[i*RW +: RW];
        // armed stays low for the first cycle after reset so a held-high trigger is not an edge
        assign trig_edge = ResetTrigger[i] & ~trig_prev & armed;
        assign end_state = Mode[i] ? S_IDLE : S_LOCKED;

        always_comb begin
            state_nx   = state;
            dcnt_nx    = dcnt;
            wcnt_nx    = wcnt;
            pulse_done = 1'b0;
            if (Cancel[i]) begin
                state_nx = S_IDLE;
                dcnt_nx  = '0;
                wcnt_nx  = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (trig_edge) begin
                            dcnt_nx = after_in;
                            wcnt_nx = width_in;
                            if (after_in != '0)      state_nx = S_WAIT;
                            else if (width_in != '0) state_nx = S_PULSE;
                            else                     state_nx = end_state;
                        end
                    end
                    S_WAIT: begin
                        if (dcnt > TW'(1)) begin
                            dcnt_nx = dcnt - TW'(1);
                        end else begin
                            dcnt_nx  = '0;
                            state_nx = (wcnt != '0) ? S_PULSE : end_state;
                        end
                    end
                    S_PULSE: begin
                        if (wcnt > RW'(1)) begin
                            wcnt_nx = wcnt - RW'(1);
                        end else begin
                            wcnt_nx    = '0;
                            pulse_done = 1'b1;
                            state_nx   = end_state;
                        end
                    end
                    S_LOCKED: begin
                        if (Rearm[i]) state_nx = S_IDLE;
                    end
                    default: state_nx = S_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                state     <= S_IDLE;
                dcnt      <= '0;
                wcnt      <= '0;
                trig_prev <= 1'b0;
                armed     <= 1'b0;
                out_q     <= ~RESETLOGIC;
            end else begin
                state     <= state_nx;
                dcnt      <= dcnt_nx;
                wcnt      <= wcnt_nx;
                trig_prev <= ResetTrigger[i];
                armed     <= 1'b1;
                out_q     <= (state_nx == S_PULSE) ? RESETLOGIC : ~RESETLOGIC;
            end
        end

        assign OneShotReset[i] = out_q;
        assign Busy[i]         = (state == S_WAIT) || (state == S_PULSE);

`ifdef MULTI_ETH_RESET_PULSE_COUNT_EN
        logic [7:0] pcnt;

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                pcnt <= '0;
            end else if (Rearm[i]) begin
                pcnt <= '0;
            end else if (pulse_done && (pcnt != 8'hFF)) begin
                pcnt <= pcnt + 8'd1;
            end
        end

        assign PulseCount[i*8 +: 8] = pcnt;
`endif
    end

endmodule

// File: tb/tb_multi_eth_reset_gen.sv
// Scoreboard bench for multi_eth_reset_gen: a timestamp-based channel model pushes per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_multi_eth_reset_gen;

    localparam int N   = 4;
    localparam int TW  = 4;
    localparam int RW  = 3;
    localparam bit ACT = 1'b1;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [N*TW-1:0]   after_bus = '0;
    logic [N*RW-1:0]   width_bus = '0;
    logic [N-1:0]      trig = '0;
    logic [N-1:0]      mode = '0;
    logic [N-1:0]      rearm = '0;
    logic [N-1:0]      cancel = '0;
    logic [N-1:0]      one_shot;
    logic [N-1:0]      busy;
`ifdef MULTI_ETH_RESET_PULSE_COUNT_EN
    logic [N*8-1:0]    pulse_count;
`endif

    multi_eth_reset_gen #(
        .TIMER_MAX_WIDTH (TW),
        .RESET_MAX_WIDTH (RW),
        .RESETLOGIC      (ACT),
        .NUM_CHANNELS    (N)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .ResetAfter   (after_bus),
        .ResetWidth   (width_bus),
        .ResetTrigger (trig),
        .Mode         (mode),
        .Rearm        (rearm),
        .Cancel       (cancel),
        .OneShotReset (one_shot),
        .Busy         (busy)
`ifdef MULTI_ETH_RESET_PULSE_COUNT_EN
        ,
        .PulseCount   (pulse_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   rst;
        logic [N-1:0]   busy;
        logic [N*8-1:0] pc;
        int             cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    // Channel model: a sequence started at edge ts is busy for A+W edges, pulsing for the last W.
    bit m_active[N];
    bit m_locked[N];
    bit m_prev[N];
    bit m_armed;
    int m_ts[N];
    int m_a[N];
    int m_w[N];
    int m_pc[N];

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0; m_locked[i] = 0; m_prev[i] = 0;
            m_ts[i] = 0; m_a[i] = 0; m_w[i] = 0; m_pc[i] = 0;
        end
        m_armed = 0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit e;
            e = trig[i] && !m_prev[i] && m_armed;
            if (cancel[i]) begin
                m_active[i] = 0;
                m_locked[i] = 0;
            end else if (m_locked[i]) begin
                if (rearm[i]) m_locked[i] = 0;
            end else if (m_active[i]) begin
                if (ncyc == m_ts[i] + m_a[i] + m_w[i]) begin
                    m_active[i] = 0;
                    m_locked[i] = !mode[i];
                    if (m_w[i] > 0 && m_pc[i] < 255) m_pc[i]++;
                end
            end else if (e) begin
                m_ts[i] = ncyc;
                m_a[i]  = int'(after_bus[i*TW +: TW]);
                m_w[i]  = int'(width_bus[i*RW +: RW]);
                if (m_a[i] + m_w[i] == 0) m_locked[i] = !mode[i];
                else                      m_active[i] = 1;
            end
            if (rearm[i]) m_pc[i] = 0;
            m_prev[i] = trig[i];
        end
        m_armed = 1;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.busy[i] = m_active[i];
            e.rst[i]  = (m_active[i] && ncyc >= m_ts[i] + m_a[i]) ? ACT : ~ACT;
            e.pc[i*8 +: 8] = 8'(m_pc[i]);
        end
        e.cyc = ncyc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        if (!aresetn) model_reset();
        else          model_edge();
        push_expected();
        ncyc++;
        #1;
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    task automatic trig_pulse(int ch);
        trig[ch] = 1'b1;
        step();
        trig[ch] = 1'b0;
    endtask

    task automatic set_ch(int ch, int a, int w, bit m);
        after_bus[ch*TW +: TW] = TW'(a);
        width_bus[ch*RW +: RW] = RW'(w);
        mode[ch] = m;
    endtask

    task automatic pulse_reset(int hold);
        @(negedge clk);
        #1;
        aresetn = 1'b0;
        #1;
        check("async_reset_out", 64'(one_shot), 64'({N{~ACT}}));
        check("async_reset_busy", 64'(busy), 64'(0));
        model_reset();
        steps(hold);
        @(negedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("out_cyc%0d", e.cyc), 64'(one_shot), 64'(e.rst));
            check($sformatf("busy_cyc%0d", e.cyc), 64'(busy), 64'(e.busy));
`ifdef MULTI_ETH_RESET_PULSE_COUNT_EN
            check($sformatf("pcount_cyc%0d", e.cyc), 64'(pulse_count), 64'(e.pc));
`endif
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_out", 64'(one_shot), 64'({N{~ACT}}));
        check("reset_busy", 64'(busy), 64'(0));
        steps(3);
        @(negedge clk);
        #1;
        aresetn = 1'b1;
        steps(2);

        // ch0 retriggerable, delay 3, width 5
        set_ch(0, 3, 5, 1'b1);
        trig_pulse(0);
        steps(12);

        // ch1 one-shot, zero delay: second edge ignored until Rearm
        set_ch(1, 0, 2, 1'b0);
        trig_pulse(1);
        steps(19);
        trig_pulse(1);
        steps(6);
        rearm[1] = 1'b1;
        step();
        rearm[1] = 1'b0;
        trig_pulse(1);
        steps(6);

        // ch2 cancelled mid-WAIT, then accepts a new edge; input change after latch has no effect
        set_ch(2, 10, 4, 1'b1);
        trig_pulse(2);
        set_ch(2, 2, 1, 1'b1);
        steps(4);
        cancel[2] = 1'b1;
        step();
        cancel[2] = 1'b0;
        steps(3);
        set_ch(2, 10, 4, 1'b1);
        trig_pulse(2);
        steps(16);

        // all channels together, staggered delays
        for (int i = 0; i < N; i++) set_ch(i, i + 1, 1, 1'b1);
        trig = '1;
        step();
        trig = '0;
        steps(8);

        // maximum field values
        set_ch(3, 15, 7, 1'b1);
        trig_pulse(3);
        steps(24);

        // reset in the middle of a pulse, trigger held through release
        set_ch(0, 0, 6, 1'b1);
        trig[0] = 1'b1;
        steps(3);
        pulse_reset(2);
        steps(10);
        trig[0] = 1'b0;
        steps(2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) trig[i] = ~trig[i];
                if ($urandom_range(0, 7) == 0)
                    after_bus[i*TW +: TW] = ($urandom_range(0, 5) == 0) ? TW'(15) : TW'($urandom_range(0, 5));
                if ($urandom_range(0, 7) == 0)
                    width_bus[i*RW +: RW] = ($urandom_range(0, 5) == 0) ? RW'(7) : RW'($urandom_range(0, 4));
                rearm[i]  = ($urandom_range(0, 15) == 0);
                cancel[i] = ($urandom_range(0, 31) == 0);
            end
            mode = N'($urandom);
            if (c == 1500) begin
                pulse_reset(1);
            end
            step();
        end
        trig = '0; rearm = '0; cancel = '0;
        steps(30);

`ifdef MULTI_ETH_RESET_PULSE_COUNT_EN
        rearm = '1;
        step();
        rearm = '0;
        set_ch(0, 0, 1, 1'b1);
        for (int p = 0; p < 300; p++) begin
            trig[0] = 1'b1;
            step();
            trig[0] = 1'b0;
            step();
        end
        steps(2);
        check("pcount_saturated", 64'(pulse_count[7:0]), 64'(255));
        rearm[0] = 1'b1;
        step();
        rearm[0] = 1'b0;
        check("pcount_rearm_clear", 64'(pulse_count[7:0]), 64'(0));
`endif

        repeat (5) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
